// File: rtl/music_sequencer.sv
// Score-ROM driven tone sequencer: walks score entries, holds each for its duration
// in sixteenth-note ticks and drives a square wave at the entry's half-period.
module music_sequencer #(
    parameter int TICK_CYCLES = 12500000,
    parameter int LAST_INDEX  = 65,
    parameter int REST_MAX    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        pause,
    input  logic        loop,
    output logic [9:0]  number,
    input  logic [19:0] note,
    input  logic [4:0]  duration,
    output logic        speaker,
    output logic        busy,
    output logic        done,
    output logic [2:0]  state_dbg
);

    localparam int              TW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [9:0]      LAST      = 10'(LAST_INDEX);
    localparam logic [19:0]     REST      = 20'(REST_MAX);

    // Handshake: start/stop are single-cycle pulses sampled on the rising edge;
    // pause/loop are levels. The score ROM answers number with note/duration in
    // the same cycle, and the entry is captured in FETCH.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_PLAY   = 3'd2,
        S_PAUSED = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t        state;
    logic [TW-1:0] tick_q;
    logic [19:0]   tone_q;
    logic [19:0]   note_q;
    logic [4:0]    dur_q;

    logic          tick_term;
    logic          entry_end;
    logic          tone_on;
    logic          tone_term;
    logic          spk_step;
    logic [TW-1:0] tick_nx;
    logic [19:0]   tone_nx;
    logic [4:0]    dur_nx;

    assign state_dbg = state;

    // One counting step; leaving PAUSED counts too, but the waveform restarts low.
    always_comb begin
        tick_term = (tick_q == TICK_LAST);
        entry_end = tick_term && (dur_q == 5'd1);
        tone_on   = (note_q > REST);
        tone_term = tone_on && (tone_q == note_q - 20'd1);
        tick_nx   = tick_term ? '0 : tick_q + TW'(1);
        dur_nx    = tick_term ? dur_q - 5'd1 : dur_q;
        tone_nx   = (!tone_on || tone_term) ? 20'd0 : tone_q + 20'd1;
        spk_step  = (state == S_PLAY) ? speaker : 1'b0;
        if (tone_term) spk_step = ~spk_step;
        if (!tone_on)  spk_step = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            number  <= '0;
            speaker <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            tick_q  <= '0;
            tone_q  <= '0;
            note_q  <= '0;
            dur_q   <= '0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state   <= S_IDLE;
                number  <= '0;
                speaker <= 1'b0;
                busy    <= 1'b0;
                tick_q  <= '0;
                tone_q  <= '0;
                dur_q   <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        number  <= '0;
                        speaker <= 1'b0;
                        busy    <= 1'b0;
                        if (start) begin
                            state <= S_FETCH;
                            busy  <= 1'b1;
                        end
                    end
                    S_FETCH: begin
                        note_q  <= note;
                        dur_q   <= (duration == 5'd0) ? 5'd1 : duration;
                        tick_q  <= '0;
                        tone_q  <= '0;
                        speaker <= 1'b0;
                        state   <= S_PLAY;
                    end
                    S_PLAY, S_PAUSED: begin
                        if (pause) begin
                            state   <= S_PAUSED;
                            speaker <= 1'b0;
                        end else begin
                            state   <= S_PLAY;
                            tick_q  <= tick_nx;
                            tone_q  <= tone_nx;
                            dur_q   <= dur_nx;
                            speaker <= spk_step;
                            if (entry_end) begin
                                speaker <= 1'b0;
                                if (number < LAST) begin
                                    number <= number + 10'd1;
                                    state  <= S_FETCH;
                                end else if (loop) begin
                                    number <= '0;
                                    state  <= S_FETCH;
                                end else begin
                                    number <= '0;
                                    state  <= S_DONE;
                                    busy   <= 1'b0;
                                    done   <= 1'b1;
                                end
                            end
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_music_sequencer.sv
// Bench for music_sequencer with a small score ROM and an elapsed-time reference model.
module tb_music_sequencer;

    localparam int T    = 4;
    localparam int LAST = 2;
    localparam int REST = 1;

    localparam int M_IDLE   = 0;
    localparam int M_FETCH  = 1;
    localparam int M_PLAY   = 2;
    localparam int M_PAUSED = 3;
    localparam int M_DONE   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        pause = 1'b0;
    logic        loop = 1'b0;
    logic [9:0]  number;
    logic [19:0] note;
    logic [4:0]  duration;
    logic        speaker;
    logic        busy;
    logic        done;
    logic [2:0]  state_dbg;

    logic [19:0] rom_note [0:LAST];
    logic [4:0]  rom_dur  [0:LAST];

    int checks = 0;
    int errors = 0;

    // Reference model: entry progress measured in counted PLAY edges.
    int m_mode, m_idx, m_note, m_len, m_el, m_ref;

    music_sequencer #(.TICK_CYCLES(T), .LAST_INDEX(LAST), .REST_MAX(REST)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause), .loop(loop),
        .number(number), .note(note), .duration(duration), .speaker(speaker),
        .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    always_comb begin
        note     = '0;
        duration = '0;
        if (int'(number) <= LAST) begin
            note     = rom_note[int'(number)];
            duration = rom_dur[int'(number)];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_idx = 0; m_note = 0; m_len = 0; m_el = 0; m_ref = 0;
    endtask

    task automatic model_count();
        m_el++;
        if (m_el == m_len) begin
            if (m_idx < LAST) begin
                m_idx++; m_mode = M_FETCH;
            end else if (loop) begin
                m_idx = 0; m_mode = M_FETCH;
            end else begin
                m_idx = 0; m_mode = M_DONE;
            end
        end
    endtask

    task automatic model_step();
        int d;
        if (!rst_n) begin model_reset(); return; end
        if (stop) begin m_mode = M_IDLE; m_idx = 0; return; end
        case (m_mode)
            M_IDLE: if (start) begin m_mode = M_FETCH; m_idx = 0; end
            M_FETCH: begin
                m_note = int'(rom_note[m_idx]);
                d      = (rom_dur[m_idx] == 5'd0) ? 1 : int'(rom_dur[m_idx]);
                m_len  = d * T;
                m_el   = 0;
                m_ref  = 0;
                m_mode = M_PLAY;
            end
            M_PLAY: if (pause) begin m_mode = M_PAUSED; m_ref = m_el; end else model_count();
            M_PAUSED: if (!pause) begin m_mode = M_PLAY; model_count(); end
            default: m_mode = M_IDLE;
        endcase
    endtask

    // Square wave restarts low after a pause; toggles counted since that restart.
    function automatic logic exp_spk();
        if (m_mode == M_PLAY && m_note > REST)
            return 1'(((m_el / m_note) - (m_ref / m_note)) % 2);
        return 1'b0;
    endfunction

    task automatic check_outputs(input string tag);
        logic e_busy;
        e_busy = (m_mode == M_FETCH || m_mode == M_PLAY || m_mode == M_PAUSED);
        chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
        chk({tag, ".done"}, 32'(done), 32'(m_mode == M_DONE));
        chk({tag, ".number"}, 32'(number), 32'(m_idx));
        chk({tag, ".speaker"}, 32'(speaker), 32'(exp_spk()));
    endtask

    task automatic step_cycle(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        logic [0:7] spk_seq;
        int saw_wrap, done_cnt;
        logic [9:0] prev_num;
        spk_seq = 8'b00011100;
        rom_note = '{20'd3, 20'd1, 20'd2};
        rom_dur  = '{5'd2, 5'd1, 5'd0};
        model_reset();

        // Reset state, then idle with pause/loop ignored.
        repeat (2) @(negedge clk);
        chk("reset.busy", 32'(busy), 0);
        chk("reset.number", 32'(number), 0);
        chk("reset.speaker", 32'(speaker), 0);
        chk("reset.done", 32'(done), 0);
        rst_n = 1'b1;
        pause = 1'b1; loop = 1'b1;
        repeat (3) step_cycle("idle");
        pause = 1'b0; loop = 1'b0;

        // Full score: tone entry, rest entry, zero-duration entry, done pulse.
        start = 1'b1; step_cycle("start"); start = 1'b0;
        chk("start.busy_latency", 32'(busy), 1);
        step_cycle("e0");
        for (int i = 0; i < 8; i++) begin
            chk("e0.spk_seq", 32'(speaker), 32'(spk_seq[i]));
            chk("e0.number_hold", 32'(number), 0);
            step_cycle("e0");
        end
        chk("e0.number_next", 32'(number), 1);
        step_cycle("e1");
        for (int i = 0; i < 4; i++) begin
            chk("e1.rest", 32'(speaker), 0);
            step_cycle("e1");
        end
        chk("e1.number_next", 32'(number), 2);
        step_cycle("e2");
        repeat (4) step_cycle("e2");
        chk("end.done", 32'(done), 1);
        chk("end.busy", 32'(busy), 0);
        chk("end.number", 32'(number), 0);
        step_cycle("end");
        chk("end.done_once", 32'(done), 0);

        // Pause for 5 cycles starting in the 3rd PLAY cycle.
        start = 1'b1; step_cycle("p_start"); start = 1'b0;
        repeat (3) step_cycle("p_play");
        pause = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step_cycle("p_hold");
            chk("pause.spk_zero", 32'(speaker), 0);
        end
        pause = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            step_cycle("p_resume");
            chk("pause.number_hold", 32'(number), 0);
        end
        step_cycle("p_resume");
        chk("pause.end_shift", 32'(number), 1);
        stop = 1'b1; step_cycle("p_stop"); stop = 1'b0;

        // Stop mid-note while the speaker is high, then restart.
        start = 1'b1; step_cycle("s_start"); start = 1'b0;
        repeat (5) step_cycle("s_play");
        chk("stop.pre_spk", 32'(speaker), 1);
        stop = 1'b1; step_cycle("s_stop"); stop = 1'b0;
        chk("stop.busy", 32'(busy), 0);
        chk("stop.speaker", 32'(speaker), 0);
        chk("stop.number", 32'(number), 0);
        step_cycle("s_idle");
        start = 1'b1; step_cycle("s_restart"); start = 1'b0;
        chk("restart.busy", 32'(busy), 1);
        chk("restart.number", 32'(number), 0);
        repeat (9) step_cycle("s_replay");
        chk("restart.number_next", 32'(number), 1);
        stop = 1'b1; step_cycle("s_stop2"); stop = 1'b0;

        // start and stop together in IDLE.
        start = 1'b1; stop = 1'b1; step_cycle("ss"); start = 1'b0; stop = 1'b0;
        chk("startstop.busy", 32'(busy), 0);
        step_cycle("ss_idle");

        // Looping: wraps 2->0 without done, then ends once loop drops.
        loop = 1'b1;
        start = 1'b1; step_cycle("l_start"); start = 1'b0;
        saw_wrap = 0;
        prev_num = number;
        for (int i = 0; i < 45; i++) begin
            step_cycle("loop");
            chk("loop.busy", 32'(busy), 1);
            chk("loop.no_done", 32'(done), 0);
            if (prev_num == 10'd2 && number == 10'd0) saw_wrap = 1;
            prev_num = number;
        end
        chk("loop.wrap", 32'(saw_wrap), 1);
        loop = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step_cycle("unloop");
            if (done) done_cnt++;
        end
        chk("unloop.done_count", 32'(done_cnt), 1);
        chk("unloop.idle_busy", 32'(busy), 0);

        // Asynchronous reset in the middle of a sounding note.
        start = 1'b1; step_cycle("r_start"); start = 1'b0;
        repeat (4) step_cycle("r_play");
        chk("rst.pre_spk", 32'(speaker), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst.async_busy", 32'(busy), 0);
        chk("rst.async_speaker", 32'(speaker), 0);
        chk("rst.async_number", 32'(number), 0);
        chk("rst.async_done", 32'(done), 0);
        model_reset();
        step_cycle("r_hold");
        rst_n = 1'b1;
        repeat (3) step_cycle("r_idle");

        // Randomized control and score contents against the model.
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 9) == 0) pause = ~pause;
            if ($urandom_range(0, 29) == 0) loop = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) begin
                for (int k = 0; k <= LAST; k++) begin
                    rom_note[k] = 20'($urandom_range(0, 4));
                    rom_dur[k]  = 5'($urandom_range(0, 3));
                end
            end
            step_cycle("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
